decode_stage: RTL and testbench

- Second stage of the 5-stage RV32I pipeline; consumes instrD/PCD/PCplus4D from the fetch stage.
- Decodes control signals, generates the sign-extended immediate and reads the 32x32 register file.
- Registers everything into the ID/EX pipeline register for the execute stage.
- Owns the architectural register file; the writeback stage writes it through the W-side ports.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/decode_stage_if.sv | 41 ++++
 rtl/reg_file.sv | 36 +++
 rtl/decode_stage.sv | 172 +++++++++++++++++
 tb/tb_decode_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU control, result-select and immediate-format encodings.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } aluCtl_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } resSrc_t;

   typedef enum logic [1:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J
   } immType_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode inputs and ID/EX register outputs of the decode stage; slave = decode stage side.
interface decode_stage_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [31:0]     instrD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCplus4D;
   logic [AW-1:0]   rs1D;
   logic [AW-1:0]   rs2D;

   logic            regWriteE;
   logic            memWriteE;
   logic            branchE;
   logic            jumpE;
   logic            aluSrcE;
   logic [1:0]      resultSrcE;
   logic [2:0]      aluControlE;
   logic [XLEN-1:0] rd1E;
   logic [XLEN-1:0] rd2E;
   logic [XLEN-1:0] immExtE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCplus4E;
   logic [AW-1:0]   rs1E;
   logic [AW-1:0]   rs2E;
   logic [AW-1:0]   rdE;

   modport slave (
      input  instrD, PCD, PCplus4D,
      output rs1D, rs2D,
      output regWriteE, memWriteE, branchE, jumpE, aluSrcE, resultSrcE, aluControlE,
      output rd1E, rd2E, immExtE, PCE, PCplus4E, rs1E, rs2E, rdE
   );

   modport master (
      output instrD, PCD, PCplus4D,
      input  rs1D, rs2D,
      input  regWriteE, memWriteE, branchE, jumpE, aluSrcE, resultSrcE, aluControlE,
      input  rd1E, rd2E, immExtE, PCE, PCplus4E, rs1E, rs2E, rdE
   );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: x0 hardwired to zero, synchronous clear, combinational reads.
// DECODE_WB_BYPASS_EN: a same-cycle writeback is forwarded to the matching read port.
module reg_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(NREGS)-1:0] ra1,
   input  logic [$clog2(NREGS)-1:0] ra2,
   input  logic                     we,
   input  logic [$clog2(NREGS)-1:0] wa,
   input  logic [XLEN-1:0]          wd,
   output logic [XLEN-1:0]          rd1,
   output logic [XLEN-1:0]          rd2
);
   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   // ra != 0 together with ra == wa already excludes a forwarded x0 write
   assign rd1 = (ra1 == '0) ? '0 : (we && ra1 == wa) ? wd : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : (we && ra2 == wa) ? wd : regs[ra2];
`else
   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
`endif

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, register-file read and the ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN enables write-before-read forwarding in reg_file.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   decode_stage_if.slave            bus,
   input  logic                     stallE,
   input  logic                     flushE,
   input  logic                     regWriteW,
   input  logic [$clog2(NREGS)-1:0] rdW,
   input  logic [XLEN-1:0]          resultW
);
   localparam int AW = $clog2(NREGS);

   logic [31:0]     instr;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [AW-1:0]   rd;

   logic            regWrite;
   logic            memWrite;
   logic            branch;
   logic            jump;
   logic            aluSrc;
   resSrc_t         resultSrc;
   aluCtl_t         aluCtl;
   aluCtl_t         aluFunc;
   immType_t        immType;
   logic [31:0]     imm32;
   logic [XLEN-1:0] immExt;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;

   assign instr    = bus.instrD;
   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7b5 = instr[30];
   assign rs1      = AW'(instr[19:15]);
   assign rs2      = AW'(instr[24:20]);
   assign rd       = AW'(instr[11:7]);

   assign bus.rs1D = rs1;
   assign bus.rs2D = rs2;

   // funct7[5] only selects sub for R-type; I-ALU has no subi
   always_comb begin
      aluFunc = ALU_ADD;
      case (funct3)
         3'b000:  aluFunc = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  aluFunc = ALU_SLT;
         3'b110:  aluFunc = ALU_OR;
         3'b111:  aluFunc = ALU_AND;
         default: aluFunc = ALU_ADD;
      endcase
   end

   always_comb begin
      regWrite  = 1'b0;
      memWrite  = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      aluSrc    = 1'b0;
      resultSrc = RES_ALU;
      aluCtl    = ALU_ADD;
      immType   = IMM_I;
      case (opcode)
         OP_LW: begin
            regWrite  = 1'b1;
            aluSrc    = 1'b1;
            resultSrc = RES_MEM;
         end
         OP_SW: begin
            memWrite = 1'b1;
            aluSrc   = 1'b1;
            immType  = IMM_S;
         end
         OP_R: begin
            regWrite = 1'b1;
            aluCtl   = aluFunc;
         end
         OP_I: begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
            aluCtl   = aluFunc;
         end
         OP_BEQ: begin
            branch  = 1'b1;
            aluCtl  = ALU_SUB;
            immType = IMM_B;
         end
         OP_JAL: begin
            regWrite  = 1'b1;
            jump      = 1'b1;
            resultSrc = RES_PC4;
            immType   = IMM_J;
         end
         default: ;
      endcase
   end

   always_comb begin
      imm32 = {{20{instr[31]}}, instr[31:20]};
      case (immType)
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = {{20{instr[31]}}, instr[31:20]};
      endcase
   end

   assign immExt = XLEN'($signed(imm32));

   reg_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) regFile (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1),
      .ra2 (rs2),
      .we  (regWriteW),
      .wa  (rdW),
      .wd  (resultW),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   always_ff @(posedge clk) begin
      if (rst || flushE) begin
         bus.regWriteE   <= 1'b0;
         bus.memWriteE   <= 1'b0;
         bus.branchE     <= 1'b0;
         bus.jumpE       <= 1'b0;
         bus.aluSrcE     <= 1'b0;
         bus.resultSrcE  <= '0;
         bus.aluControlE <= '0;
         bus.rd1E        <= '0;
         bus.rd2E        <= '0;
         bus.immExtE     <= '0;
         bus.PCE         <= '0;
         bus.PCplus4E    <= '0;
         bus.rs1E        <= '0;
         bus.rs2E        <= '0;
         bus.rdE         <= '0;
      end else if (!stallE) begin
         bus.regWriteE   <= regWrite;
         bus.memWriteE   <= memWrite;
         bus.branchE     <= branch;
         bus.jumpE       <= jump;
         bus.aluSrcE     <= aluSrc;
         bus.resultSrcE  <= resultSrc;
         bus.aluControlE <= aluCtl;
         bus.rd1E        <= rd1;
         bus.rd2E        <= rd2;
         bus.immExtE     <= immExt;
         bus.PCE         <= bus.PCD;
         bus.PCplus4E    <= bus.PCplus4D;
         bus.rs1E        <= rs1;
         bus.rs2E        <= rs2;
         bus.rdE         <= rd;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage; expectations come from hand-encoded tables and a reference register model.
module tb_decode_stage;

   typedef struct packed {
      logic        regWrite;
      logic        memWrite;
      logic        branch;
      logic        jump;
      logic        aluSrc;
      logic [1:0]  resultSrc;
      logic [2:0]  aluControl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] immExt;
      logic [31:0] PC;
      logic [31:0] PCplus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } eBus_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallE;
   logic        flushE;
   logic        regWriteW;
   logic [4:0]  rdW;
   logic [31:0] resultW;

   decode_stage_if #(.XLEN(32), .AW(5)) bus ();

   decode_stage #(.XLEN(32), .NREGS(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .stallE    (stallE),
      .flushE    (flushE),
      .regWriteW (regWriteW),
      .rdW       (rdW),
      .resultW   (resultW)
   );

   always #5 clk = ~clk;

   int          passCount  = 0;
   int          checkCount = 0;
   int          failCount  = 0;
   logic [31:0] refRegs [32];
   logic [31:0] pcNext;
   eBus_t       lastExp;
   eBus_t       lastMask;
   eBus_t       expQ  [$];
   eBus_t       maskQ [$];
   string       tagQ  [$];

   function automatic logic [9:0] ctl(input bit rw, input bit mw, input bit br, input bit jp,
                                      input bit as, input logic [1:0] rs, input logic [2:0] alu);
      return {rw, mw, br, jp, as, rs, alu};
   endfunction

   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rdst);
      return {f7, r2, r1, f3, rdst, 7'b0110011};
   endfunction

   function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rdst);
      return {imm, r1, f3, rdst, 7'b0010011};
   endfunction

   function automatic logic [31:0] stype(input logic [11:0] imm, input logic [4:0] r2, input logic [4:0] r1);
      return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] jtype(input logic [20:0] imm, input logic [4:0] rdst);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rdst, 7'b1101111};
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] a, input bit wen, input logic [4:0] wrd,
                                         input logic [31:0] wdata);
      if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (wen && wrd == a) return wdata;
`endif
      return refRegs[a];
   endfunction

   function automatic eBus_t sampleE();
      eBus_t o;
      o.regWrite   = bus.regWriteE;
      o.memWrite   = bus.memWriteE;
      o.branch     = bus.branchE;
      o.jump       = bus.jumpE;
      o.aluSrc     = bus.aluSrcE;
      o.resultSrc  = bus.resultSrcE;
      o.aluControl = bus.aluControlE;
      o.rd1        = bus.rd1E;
      o.rd2        = bus.rd2E;
      o.immExt     = bus.immExtE;
      o.PC         = bus.PCE;
      o.PCplus4    = bus.PCplus4E;
      o.rs1        = bus.rs1E;
      o.rs2        = bus.rs2E;
      o.rd         = bus.rdE;
      return o;
   endfunction

   task automatic push(input string tag, input eBus_t e, input eBus_t m);
      expQ.push_back(e);
      maskQ.push_back(m);
      tagQ.push_back(tag);
      lastExp  = e;
      lastMask = m;
   endtask

   task automatic checkOut();
      eBus_t obs, e, m;
      string tag;
      if (expQ.size() == 0) begin
         checkCount++;
         failCount++;
         $error("FAIL scoreboard-empty obs=none exp=entry");
         return;
      end
      obs = sampleE();
      e   = expQ.pop_front();
      m   = maskQ.pop_front();
      tag = tagQ.pop_front();
      checkCount++;
      assert ((obs & m) === (e & m)) passCount++;
      else begin
         failCount++;
         $error("FAIL %s obs=%h exp=%h mask=%h", tag, obs, e, m);
      end
   endtask

   task automatic step(input string tag, input logic [31:0] instr, input logic [9:0] c,
                       input logic [31:0] imm, input bit immCare, input bit wen = 1'b0,
                       input logic [4:0] wrd = 5'd0, input logic [31:0] wdata = 32'd0);
      eBus_t e, m;
      e = '0;
      {e.regWrite, e.memWrite, e.branch, e.jump, e.aluSrc, e.resultSrc, e.aluControl} = c;
      e.rd1     = mread(instr[19:15], wen, wrd, wdata);
      e.rd2     = mread(instr[24:20], wen, wrd, wdata);
      e.immExt  = imm;
      e.PC      = pcNext;
      e.PCplus4 = pcNext + 32'd4;
      e.rs1     = instr[19:15];
      e.rs2     = instr[24:20];
      e.rd      = instr[11:7];
      m = '1;
      if (!immCare) m.immExt = '0;
      push(tag, e, m);

      bus.instrD   = instr;
      bus.PCD      = pcNext;
      bus.PCplus4D = pcNext + 32'd4;
      stallE       = 1'b0;
      flushE       = 1'b0;
      regWriteW    = wen;
      rdW          = wrd;
      resultW      = wdata;
      pcNext       = pcNext + 32'd4;
      #1;
      checkCount++;
      assert (bus.rs1D === instr[19:15] && bus.rs2D === instr[24:20]) passCount++;
      else begin
         failCount++;
         $error("FAIL %s-rsD obs=%h/%h exp=%h/%h", tag, bus.rs1D, bus.rs2D, instr[19:15], instr[24:20]);
      end
      @(posedge clk);
      if (wen && wrd != 5'd0) refRegs[wrd] = wdata;
      #1;
      checkOut();
      regWriteW = 1'b0;
   endtask

   task automatic hold(input string tag, input logic [31:0] instr, input bit stall, input bit flush);
      eBus_t e, m;
      if (flush) begin
         e = '0;
         m = '1;
      end else begin
         e = lastExp;
         m = lastMask;
      end
      push(tag, e, m);
      bus.instrD   = instr;
      bus.PCD      = pcNext;
      bus.PCplus4D = pcNext + 32'd4;
      pcNext       = pcNext + 32'd4;
      stallE       = stall;
      flushE       = flush;
      @(posedge clk);
      #1;
      checkOut();
      stallE = 1'b0;
      flushE = 1'b0;
   endtask

   task automatic resetStep(input string tag);
      rst          = 1'b1;
      stallE       = 1'b1;
      bus.instrD   = 32'h000281B3;
      bus.PCD      = 32'h0000_0400;
      bus.PCplus4D = 32'h0000_0404;
      push(tag, '0, '1);
      @(posedge clk);
      for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
      #1;
      checkOut();
      stallE = 1'b0;
      pcNext = 32'd0;
   endtask

   initial begin
      rst = 1'b1; stallE = 1'b0; flushE = 1'b0;
      regWriteW = 1'b0; rdW = 5'd0; resultW = 32'd0;
      bus.instrD = 32'd0; bus.PCD = 32'd0; bus.PCplus4D = 32'd0;
      pcNext = 32'd0;
      lastExp = '0;
      lastMask = '1;
      for (int i = 0; i < 32; i++) refRegs[i] = 32'hX;

      resetStep("reset1");
      resetStep("reset2");
      rst = 1'b0;

      step("idle", 32'd0, 10'd0, 32'd0, 1'b1);
      for (int i = 1; i < 32; i++)
         step("rdzero", rtype(7'd0, 5'(32 - i), 5'(i), 3'b000, 5'd0),
              ctl(1, 0, 0, 0, 0, 2'b00, 3'b000), 32'd0, 1'b0);

      step("wr-x5", 32'd0, 10'd0, 32'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
      step("add", 32'h000281B3, ctl(1, 0, 0, 0, 0, 2'b00, 3'b000), 32'd0, 1'b0);
      step("wr-x0", 32'd0, 10'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h0000_1234);
      step("rd-x0", rtype(7'd0, 5'd5, 5'd0, 3'b000, 5'd1), ctl(1, 0, 0, 0, 0, 2'b00, 3'b000), 32'd0, 1'b0);
      step("sub", rtype(7'h20, 5'd0, 5'd5, 3'b000, 5'd2), ctl(1, 0, 0, 0, 0, 2'b00, 3'b001), 32'd0, 1'b0);
      step("slt", rtype(7'd0, 5'd5, 5'd3, 3'b010, 5'd4), ctl(1, 0, 0, 0, 0, 2'b00, 3'b101), 32'd0, 1'b0);
      step("or", rtype(7'd0, 5'd5, 5'd3, 3'b110, 5'd4), ctl(1, 0, 0, 0, 0, 2'b00, 3'b011), 32'd0, 1'b0);
      step("and", rtype(7'd0, 5'd5, 5'd3, 3'b111, 5'd4), ctl(1, 0, 0, 0, 0, 2'b00, 3'b010), 32'd0, 1'b0);
      step("xor-add", rtype(7'd0, 5'd5, 5'd3, 3'b100, 5'd4), ctl(1, 0, 0, 0, 0, 2'b00, 3'b000), 32'd0, 1'b0);
      step("addi-m1", itype(12'hFFF, 5'd5, 3'b000, 5'd4), ctl(1, 0, 0, 0, 1, 2'b00, 3'b000), 32'hFFFF_FFFF, 1'b1);
      step("ori", itype(12'h7FF, 5'd5, 3'b110, 5'd6), ctl(1, 0, 0, 0, 1, 2'b00, 3'b011), 32'h0000_07FF, 1'b1);
      step("lw", 32'hFFC12083, ctl(1, 0, 0, 0, 1, 2'b01, 3'b000), 32'hFFFF_FFFC, 1'b1);
      step("sw-p8", stype(12'h008, 5'd5, 5'd2), ctl(0, 1, 0, 0, 1, 2'b00, 3'b000), 32'h0000_0008, 1'b1);
      step("sw-m20", stype(12'hFEC, 5'd5, 5'd2), ctl(0, 1, 0, 0, 1, 2'b00, 3'b000), 32'hFFFF_FFEC, 1'b1);
      step("beq", 32'hFE000CE3, ctl(0, 0, 1, 0, 0, 2'b00, 3'b001), 32'hFFFF_FFF8, 1'b1);
      step("jal-m4", jtype(21'h1FFFFC, 5'd1), ctl(1, 0, 0, 1, 0, 2'b10, 3'b000), 32'hFFFF_FFFC, 1'b1);
      step("jal-2k", jtype(21'h000800, 5'd2), ctl(1, 0, 0, 1, 0, 2'b10, 3'b000), 32'h0000_0800, 1'b1);
      step("unknown", 32'hFFFF_F0FF, 10'd0, 32'd0, 1'b0);

      step("pre-stall", itype(12'h123, 5'd5, 3'b000, 5'd9), ctl(1, 0, 0, 0, 1, 2'b00, 3'b000), 32'h0000_0123, 1'b1);
      hold("stall1", 32'h000281B3, 1'b1, 1'b0);
      hold("stall2", 32'hFE000CE3, 1'b1, 1'b0);
      hold("flush-stall", 32'h000281B3, 1'b1, 1'b1);
      step("resume", 32'h000281B3, ctl(1, 0, 0, 0, 0, 2'b00, 3'b000), 32'd0, 1'b0);
      hold("flush", 32'hFFC12083, 1'b0, 1'b1);

      step("wr-x7", 32'd0, 10'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'h1111_1111);
      step("bypass", rtype(7'd0, 5'd7, 5'd7, 3'b000, 5'd8), ctl(1, 0, 0, 0, 0, 2'b00, 3'b000), 32'd0, 1'b0,
           1'b1, 5'd7, 32'hA5A5_A5A5);
      step("after-wr", rtype(7'd0, 5'd7, 5'd7, 3'b000, 5'd8), ctl(1, 0, 0, 0, 0, 2'b00, 3'b000), 32'd0, 1'b0);

      resetStep("reset-stall");
      rst = 1'b0;
      step("rf-cleared", rtype(7'd0, 5'd7, 5'd5, 3'b000, 5'd3), ctl(1, 0, 0, 0, 0, 2'b00, 3'b000), 32'd0, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
